// File: rtl/axis_pkg.sv
// Shared types and helpers for the narrow-to-wide stream packer.
package axis_pkg;

  typedef enum logic [0:0] {EMPTY, HOLD} PackState_t;

  // Lane index width. A one-bit floor keeps the counter legal for every RATIO.
  function automatic int lane_idx_width(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_width_packer_if.sv
// Stream bundle for axis_width_packer: narrow input side (s_*) and wide output side (m_*).
// AXIS_WIDTH_PACKER_LAST_EN adds s_last, m_last and m_keep.
interface axis_width_packer_if #(
  parameter int BITWIDTH = 8,
  parameter int RATIO    = 4
);
  logic                      s_valid;
  logic                      s_ready;
  logic [BITWIDTH-1:0]       s_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [RATIO*BITWIDTH-1:0] m_data;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
  logic                      s_last;
  logic                      m_last;
  logic [RATIO-1:0]          m_keep;

  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data, m_last, m_keep);
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data, m_last, m_keep);
`else
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data);
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data);
`endif
endinterface

// File: rtl/axis_width_packer.sv
// Packs RATIO narrow beats into one registered wide word, lane 0 = first beat.
// Optional AXIS_WIDTH_PACKER_LAST_EN: s_last ends a short word, reported via m_keep/m_last.
module axis_width_packer
  import axis_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic             clk,
  input  logic             rst,
  axis_width_packer_if.slave bus
);

  localparam int IW = lane_idx_width(RATIO);
  localparam int WW = RATIO * BITWIDTH;
  localparam int AW = (RATIO - 1) * BITWIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  if (RATIO < 2) begin : g_ratio_check
    $error("axis_width_packer: RATIO must be >= 2");
  end

  PackState_t    state_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] acc_q;
  logic [WW-1:0] m_data_q;
  logic [WW-1:0] word_d;
  logic          s_last_w;
  logic          complete_term;
  logic          s_rdy;
  logic          s_ok;
  logic          m_ok;
  logic          complete;

`ifdef AXIS_WIDTH_PACKER_LAST_EN
  logic [RATIO-1:0] m_keep_q;
  logic [RATIO-1:0] keep_d;
  logic             m_last_q;

  assign s_last_w   = bus.s_last;
  assign bus.m_keep = m_keep_q;
  assign bus.m_last = m_last_q;

  always_comb begin
    keep_d = '0;
    for (int i = 0; i < RATIO; i++) keep_d[i] = (IW'(i) <= idx_q);
  end
`else
  assign s_last_w = 1'b0;
`endif

  // Only the completing beat can stall, and only behind an unaccepted word.
  assign complete_term = (idx_q == LAST_IDX) || s_last_w;
  assign s_rdy         = !complete_term || (state_q == EMPTY) || bus.m_ready;
  assign s_ok          = bus.s_valid && s_rdy;
  assign m_ok          = (state_q == HOLD) && bus.m_ready;
  assign complete      = s_ok && complete_term;

  assign bus.s_ready = s_rdy;
  assign bus.m_valid = (state_q == HOLD);
  assign bus.m_data  = m_data_q;

  // Lanes at and above idx are still zero in the accumulator, so dropping the
  // current beat into lane idx yields the zero-padded word for short words too.
  always_comb begin
    word_d = {{BITWIDTH{1'b0}}, acc_q};
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IW'(i)) word_d[i*BITWIDTH +: BITWIDTH] = bus.s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      idx_q    <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
      m_keep_q <= '0;
      m_last_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        EMPTY: if (complete) state_q <= HOLD;
        HOLD:  if (!complete && m_ok) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase

      if (complete) begin
        m_data_q <= word_d;
        idx_q    <= '0;
        acc_q    <= '0;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
        m_keep_q <= keep_d;
        m_last_q <= s_last_w;
`endif
      end else if (s_ok) begin
        idx_q <= idx_q + IW'(1);
        for (int i = 0; i < RATIO - 1; i++) begin
          if (idx_q == IW'(i)) acc_q[i*BITWIDTH +: BITWIDTH] <= bus.s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_width_packer.sv
// Self-checking bench for axis_width_packer: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours AXIS_WIDTH_PACKER_LAST_EN.
module tb_axis_width_packer;

  localparam int BW = 8;
  localparam int R  = 4;
  localparam int WW = BW * R;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_width_packer_if #(.BITWIDTH(BW), .RATIO(R)) bus ();

  axis_width_packer #(.BITWIDTH(BW), .RATIO(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: accepted beats of the open word, plus the word on the output.
  logic [BW-1:0] mdl_beats[$];
  bit            mdl_valid;
  logic [WW-1:0] mdl_word;
  logic [R-1:0]  mdl_keep;
  bit            mdl_last;

  function automatic bit cur_last();
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    return bus.s_last;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit mdl_s_ready();
    bit finishing;
    finishing = (mdl_beats.size() == R - 1) || cur_last();
    return !(finishing && mdl_valid && !bus.m_ready);
  endfunction

  task automatic mdl_reset();
    mdl_beats.delete();
    mdl_valid = 1'b0;
    mdl_word  = '0;
    mdl_keep  = '0;
    mdl_last  = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [BW-1:0] d, input bit mr, input bit lst);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.m_ready = mr;
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    bus.s_last  = lst;
`else
    if (lst) $display("note: s_last requested without AXIS_WIDTH_PACKER_LAST_EN, ignored");
`endif
  endtask

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    bit            sok, mok, lst, done;
    logic [BW-1:0] d;
    d    = bus.s_data;
    lst  = cur_last();
    sok  = bus.s_valid && mdl_s_ready();
    mok  = mdl_valid && bus.m_ready;
    done = 1'b0;
    @(posedge clk);
    if (sok) begin
      mdl_beats.push_back(d);
      done = lst || (mdl_beats.size() == R);
    end
    if (done) begin
      mdl_word = '0;
      mdl_keep = '0;
      foreach (mdl_beats[i]) begin
        mdl_word[i*BW +: BW] = mdl_beats[i];
        mdl_keep[i] = 1'b1;
      end
      mdl_last  = lst;
      mdl_valid = 1'b1;
      mdl_beats.delete();
    end else if (mok) begin
      mdl_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    mdl_reset();
    @(negedge clk);
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid);
    end
    vectors++;
    if (bus.m_data !== '0) begin
      miscompares++;
      $display("FAIL reset_m_data got=%h exp=0", bus.m_data);
    end
    vectors++;
    if (bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_s_ready got=%b exp=1", bus.s_ready);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_m_valid got=%b exp=0", bus.m_valid);
    end
  endtask

  task automatic test_basic_pack();
    logic [BW-1:0] beats[4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, beats[i], 1'b1, 1'b0);
      #1;
      vectors++;
      if (bus.s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_s_ready beat=%0d got=%b exp=1", i, bus.s_ready);
      end
      tick();
      if (i < 3) begin
        vectors++;
        if (bus.m_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_early_valid beat=%0d got=%b exp=0", i, bus.m_valid);
        end
      end
    end
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h44332211) begin
      miscompares++;
      $display("FAIL basic_word valid=%b data=%h exp valid=1 data=44332211", bus.m_valid, bus.m_data);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 32'h44332211) begin
      miscompares++;
      $display("FAIL basic_one_cycle valid=%b data=%h exp valid=0 data=44332211", bus.m_valid, bus.m_data);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] beats[8];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, beats[i], 1'b0, 1'b0);
      #1;
      vectors++;
      if (bus.s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_accept beat=%0d got=%b exp=1", i, bus.s_ready);
      end
      tick();
      if (i >= 3) begin
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h44332211) begin
          miscompares++;
          $display("FAIL bp_hold beat=%0d valid=%b data=%h exp valid=1 data=44332211", i, bus.m_valid, bus.m_data);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, beats[7], 1'b0, 1'b0);
      #1;
      vectors++;
      if (bus.s_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall cycle=%0d got=%b exp=0", c, bus.s_ready);
      end
      tick();
      vectors++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h44332211) begin
        miscompares++;
        $display("FAIL bp_stall_hold cycle=%0d valid=%b data=%h exp valid=1 data=44332211", c, bus.m_valid, bus.m_data);
      end
    end
    drive(1'b1, beats[7], 1'b1, 1'b0);
    #1;
    vectors++;
    if (bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_s_ready got=%b exp=1", bus.s_ready);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h88776655) begin
      miscompares++;
      $display("FAIL bp_second_word valid=%b data=%h exp valid=1 data=88776655", bus.m_valid, bus.m_data);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_simultaneous();
    logic [WW-1:0] word_a, word_b;
    word_a = WW'($urandom);
    word_b = WW'($urandom);
    for (int i = 0; i < R; i++) begin
      drive(1'b1, word_a[i*BW +: BW], 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < R - 1; i++) begin
      drive(1'b1, word_b[i*BW +: BW], 1'b0, 1'b0);
      tick();
    end
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== word_a) begin
      miscompares++;
      $display("FAIL simul_hold_a valid=%b data=%h exp valid=1 data=%h", bus.m_valid, bus.m_data, word_a);
    end
    drive(1'b1, word_b[(R-1)*BW +: BW], 1'b1, 1'b0);
    #1;
    vectors++;
    if (bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_s_ready got=%b exp=1", bus.s_ready);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== word_b) begin
      miscompares++;
      $display("FAIL simul_word_b valid=%b data=%h exp valid=1 data=%h", bus.m_valid, bus.m_data, word_b);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_drain valid=%b exp=0", bus.m_valid);
    end
  endtask

  task automatic test_full_throughput();
    int words;
    words = 0;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, BW'($urandom), 1'b1, 1'b0);
      #1;
      vectors++;
      if (bus.s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL tput_s_ready cycle=%0d got=%b exp=1", c, bus.s_ready);
      end
      tick();
      vectors++;
      if (bus.m_valid !== mdl_valid || (mdl_valid && bus.m_data !== mdl_word)) begin
        miscompares++;
        $display("FAIL tput_word cycle=%0d valid=%b data=%h exp valid=%b data=%h",
                 c, bus.m_valid, bus.m_data, mdl_valid, mdl_word);
      end
      if (bus.m_valid === 1'b1) words++;
    end
    vectors++;
    if (words != 4) begin
      miscompares++;
      $display("FAIL tput_count got=%0d exp=4", words);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < R; i++) begin
      drive(1'b1, BW'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hBB, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async valid=%b data=%h exp valid=0 data=0", bus.m_valid, bus.m_data);
    end
    #1 rst = 1'b0;
    mdl_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, BW'(i + 1), 1'b1, 1'b0);
      tick();
    end
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h04030201) begin
      miscompares++;
      $display("FAIL rstmid_word valid=%b data=%h exp valid=1 data=04030201", bus.m_valid, bus.m_data);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

`ifdef AXIS_WIDTH_PACKER_LAST_EN
  task automatic test_last();
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hBB, 1'b1, 1'b1);
    tick();
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h0000BBAA || bus.m_keep !== 4'b0011 || bus.m_last !== 1'b1) begin
      miscompares++;
      $display("FAIL last_short valid=%b data=%h keep=%b last=%b exp 1 0000bbaa 0011 1",
               bus.m_valid, bus.m_data, bus.m_keep, bus.m_last);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, BW'(8'hC0 + i), 1'b1, 1'b0);
      tick();
    end
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hC3C2C1C0 || bus.m_keep !== 4'b1111 || bus.m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL last_full valid=%b data=%h keep=%b last=%b exp 1 c3c2c1c0 1111 0",
               bus.m_valid, bus.m_data, bus.m_keep, bus.m_last);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 7), BW'($urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0));
`ifndef AXIS_WIDTH_PACKER_LAST_EN
      bus.s_valid = bus.s_valid;
`endif
      #1;
      vectors++;
      if (bus.s_ready !== mdl_s_ready()) begin
        miscompares++;
        $display("FAIL rand_s_ready cycle=%0d got=%b exp=%b", c, bus.s_ready, mdl_s_ready());
      end
      tick();
      vectors++;
      if (bus.m_valid !== mdl_valid || bus.m_data !== mdl_word) begin
        miscompares++;
        $display("FAIL rand_word cycle=%0d valid=%b data=%h exp valid=%b data=%h",
                 c, bus.m_valid, bus.m_data, mdl_valid, mdl_word);
      end
`ifdef AXIS_WIDTH_PACKER_LAST_EN
      vectors++;
      if (bus.m_keep !== mdl_keep || bus.m_last !== mdl_last) begin
        miscompares++;
        $display("FAIL rand_keep_last cycle=%0d keep=%b last=%b exp keep=%b last=%b",
                 c, bus.m_keep, bus.m_last, mdl_keep, mdl_last);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_backpressure();
    test_simultaneous();
    test_full_throughput();
    test_reset_mid_word();
`ifdef AXIS_WIDTH_PACKER_LAST_EN
    test_last();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
